input_unit: RTL and testbench

INPUT_UNIT -- requirements
Module: input_unit

---
 rtl/input_unit_pkg.sv | 26 ++
 rtl/xy_route.sv | 33 +++
 rtl/input_unit.sv | 89 ++++++++
 tb/tb_input_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/input_unit_pkg.sv
// Router input-port definitions: flit field offsets and output-port
// label codes shared by the input unit and the switch allocator.
package input_unit_pkg;

  localparam int SRC_HI  = 39;
  localparam int SRC_LO  = 36;
  localparam int DST_HI  = 35;
  localparam int DST_LO  = 32;
  localparam int TS_HI   = 31;
  localparam int TS_LO   = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 2;
  localparam int TYPE_HI = 1;
  localparam int TYPE_LO = 0;

  localparam int LABEL_W = 4;

  typedef enum logic [LABEL_W-1:0] {
    PORT_L = 4'd0,
    PORT_N = 4'd1,
    PORT_E = 4'd2,
    PORT_S = 4'd3,
    PORT_W = 4'd4
  } port_e;

endpackage

// File: rtl/xy_route.sv
// Combinational XY route: resolves column first, then row, into a
// local output-port label for a 2x2-bit mesh destination.
module xy_route
  import input_unit_pkg::*;
#(
  parameter int X_ID = 0,
  parameter int Y_ID = 0
) (
  input  logic [3:0]         dst,
  output logic [LABEL_W-1:0] label
);

  localparam logic [1:0] XC = 2'(X_ID);
  localparam logic [1:0] YC = 2'(Y_ID);

  logic [1:0] dx;
  logic [1:0] dy;

  assign dx = dst[3:2];
  assign dy = dst[1:0];

  always_comb begin
    label = PORT_L;
    unique case (1'b1)
      (dx > XC):              label = PORT_E;
      (dx < XC):              label = PORT_W;
      (dx == XC && dy > YC):  label = PORT_N;
      (dx == XC && dy < YC):  label = PORT_S;
      (dx == XC && dy == YC): label = PORT_L;
    endcase
  end

endmodule

// File: rtl/input_unit.sv
// Router input port: circular flit buffer with XY route label computed
// on the write path and stored beside each flit.
module input_unit
  import input_unit_pkg::*;
#(
  parameter int DATASIZE = 40,
  parameter int DEPTH    = 4,
  parameter int X_ID     = 0,
  parameter int Y_ID     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATASIZE-1:0]       in_data,
  output logic                      full,
  output logic                      out_valid,
  output logic [DATASIZE-1:0]       out_data,
  output logic [LABEL_W-1:0]        out_label,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATASIZE-1:0] flit_mem  [DEPTH];
  logic [LABEL_W-1:0]  label_mem [DEPTH];

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic [LABEL_W-1:0] wr_label;

  // Handshake status comes from the registered count only.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign occupancy = count;

  assign push = in_valid & ~full;
  assign pop  = out_valid & out_ready;

  xy_route #(
    .X_ID (X_ID),
    .Y_ID (Y_ID)
  ) u_route (
    .dst   (in_data[DST_HI:DST_LO]),
    .label (wr_label)
  );

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      flit_mem[wr_ptr]  <= in_data;
      label_mem[wr_ptr] <= wr_label;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  assign out_data  = out_valid ? flit_mem[rd_ptr]  : '0;
  assign out_label = out_valid ? label_mem[rd_ptr] : '0;

  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) count <= CW'(DEPTH)
  );

  a_label_legal: assert property (
    @(posedge clk) disable iff (rst) out_label <= LABEL_W'(PORT_W)
  );

endmodule

// File: tb/tb_input_unit.sv
// Scoreboard bench for input_unit: directed pushes queue their expected
// flit and label; a negedge monitor checks the head against the queue.
module tb_input_unit;
  import input_unit_pkg::*;

  localparam int DS    = 40;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DS-1:0] in_data = '0;
  logic          full;
  logic          out_valid;
  logic          overflow;
  logic [DS-1:0] out_data;
  logic [3:0]    out_label;
  logic [2:0]    occupancy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq      = 0;
  logic ovf_exp  = 1'b0;

  typedef struct {
    logic [DS-1:0] d;
    logic [3:0]    l;
  } exp_t;

  exp_t q[$];

  // Hand-computed XY labels for X_ID=Y_ID=1.
  logic [3:0] dtab [8] = '{4'b1001, 4'b0101, 4'b0110, 4'b0100,
                           4'b0001, 4'b1111, 4'b0000, 4'b0111};
  logic [3:0] ltab [8] = '{4'd2, 4'd0, 4'd1, 4'd3,
                           4'd4, 4'd2, 4'd4, 4'd1};

  always #5 clk = ~clk;

  input_unit #(
    .DATASIZE (DS),
    .DEPTH    (DEPTH),
    .X_ID     (1),
    .Y_ID     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .full      (full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_label (out_label),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DS-1:0] mk(logic [3:0] dst, int s);
    logic [7:0]  s8;
    logic [21:0] pl;
    s8 = 8'(s);
    pl = 22'(s * 37 + 5);
    return {s8[3:0], dst, s8 ^ 8'hA5, pl, s8[1:0]};
  endfunction

  task automatic step(logic v, logic [3:0] dst, logic [3:0] lbl,
                      logic rdy, logic r);
    logic push_ok;
    exp_t e;
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    in_data   = mk(dst, seq);
    seq++;
    push_ok = v && !r && (q.size() < DEPTH);
    if (v && !r && q.size() == DEPTH) ovf_exp = 1'b1;
    e.d = in_data;
    e.l = lbl;
    @(posedge clk);
    if (r) begin
      q.delete();
      ovf_exp = 1'b0;
    end else if (push_ok) begin
      q.push_back(e);
    end
    #1;
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("overflow", 64'(overflow), 64'(ovf_exp));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++)
      step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() != 0) begin
        check("head_valid", 64'(out_valid), 64'd1);
        check("head_data", 64'(out_data), 64'(q[0].d));
        check("head_label", 64'(out_label), 64'(q[0].l));
        if (out_ready) void'(q.pop_front());
      end else begin
        check("empty_valid", 64'(out_valid), 64'd0);
        check("empty_data", 64'(out_data), 64'd0);
        check("empty_label", 64'(out_label), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

    step(1'b1, 4'b1001, PORT_E, 1'b0, 1'b0);
    step(1'b1, 4'b0101, PORT_L, 1'b0, 1'b0);
    drain();

    step(1'b1, 4'b0110, PORT_N, 1'b0, 1'b0);
    step(1'b1, 4'b0100, PORT_S, 1'b0, 1'b0);
    step(1'b1, 4'b0001, PORT_W, 1'b0, 1'b0);
    drain();

    // Fill, overflow, then push+pop at full.
    for (int i = 0; i < 4; i++)
      step(1'b1, dtab[i], ltab[i], 1'b0, 1'b0);
    step(1'b1, 4'b1111, PORT_E, 1'b0, 1'b0);
    step(1'b1, 4'b0000, PORT_W, 1'b1, 1'b0);
    drain();

    // Streaming at occupancy 2 across pointer wrap.
    step(1'b1, dtab[4], ltab[4], 1'b0, 1'b0);
    step(1'b1, dtab[5], ltab[5], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, dtab[i % 8], ltab[i % 8], 1'b1, 1'b0);
    drain();

    // Reset mid-operation with a push pending.
    for (int i = 0; i < 3; i++)
      step(1'b1, dtab[i + 2], ltab[i + 2], 1'b0, 1'b0);
    step(1'b1, 4'b1001, PORT_E, 1'b1, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'b0111, PORT_N, 1'b0, 1'b0);
    drain();

    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
